// File: rtl/br_update_queue.sv
// Branch-update FIFO merging two branch-unit ports into one predictor update stream.
// Optional same-cycle bypass on an empty queue: define BR_UPDATE_QUEUE_BYPASS_EN.
module br_update_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BID_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_valid,
    input  logic [31:0]      p0_pc,
    input  logic [31:0]      p0_target,
    input  logic             p0_taken,
    input  logic [1:0]       p0_br_type,
    input  logic             p0_csr_branch,
    input  logic [BID_W-1:0] p0_bid,
    input  logic             p1_valid,
    input  logic [31:0]      p1_pc,
    input  logic [31:0]      p1_target,
    input  logic             p1_taken,
    input  logic [1:0]       p1_br_type,
    input  logic [BID_W-1:0] p1_bid,
    input  logic             flush,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [1:0]       upd_br_type,
    output logic             upd_csr_branch,
    output logic [BID_W-1:0] upd_bid,
    output logic             stall,
    output logic             overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      target;
        logic             taken;
        logic [1:0]       br_type;
        logic             csr_branch;
        logic [BID_W-1:0] bid;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    entry_t     p0_e, p1_e, head, wr0_data;
    logic       fifo_deq, enq0, enq1, wr0_en, wr1_en, drop;
    logic [1:0] n_wr;
    logic [CNT_W:0] free;

    assign p0_e = '{pc: p0_pc, target: p0_target, taken: p0_taken, br_type: p0_br_type,
                    csr_branch: p0_csr_branch, bid: p0_bid};
    assign p1_e = '{pc: p1_pc, target: p1_target, taken: p1_taken, br_type: p1_br_type,
                    csr_branch: 1'b0, bid: p1_bid};

    // Only a stored entry is popped; a bypassed update never touches the FIFO.
    assign fifo_deq = (count_q != '0) && upd_ready;
    assign free     = (CNT_W + 1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, fifo_deq};

`ifdef BR_UPDATE_QUEUE_BYPASS_EN
    logic byp_active, byp_take;
    assign byp_active = (count_q == '0) && !flush && (p0_valid || p1_valid);
    assign byp_take   = byp_active && upd_ready;
    assign enq0       = p0_valid && !byp_take;
    assign enq1       = p1_valid && !(byp_take && !p0_valid);
`else
    assign enq0 = p0_valid;
    assign enq1 = p1_valid;
`endif

    // Requests fill free slots in port order; anything beyond free space is dropped.
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        drop     = 1'b0;
        wr0_data = enq0 ? p0_e : p1_e;
        if (enq0 && enq1) begin
            wr0_en = free != '0;
            wr1_en = free > (CNT_W + 1)'(1);
            drop   = !wr1_en;
        end else if (enq0 || enq1) begin
            wr0_en = free != '0;
            drop   = !wr0_en;
        end
    end

    assign n_wr = {1'b0, wr0_en} + {1'b0, wr1_en};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_wr);
            rd_ptr_q <= rd_ptr_q + PTR_W'(fifo_deq);
            count_q  <= count_q + CNT_W'(n_wr) - CNT_W'(fifo_deq);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (wr0_en) begin
                mem[wr_ptr_q] <= wr0_data;
            end
            if (wr1_en) begin
                mem[PTR_W'(wr_ptr_q + 1'b1)] <= p1_e;
            end
        end
    end

    always_comb begin
        upd_valid = count_q != '0;
        head      = mem[rd_ptr_q];
`ifdef BR_UPDATE_QUEUE_BYPASS_EN
        if (byp_active) begin
            upd_valid = 1'b1;
            head      = p0_valid ? p0_e : p1_e;
        end
`endif
    end

    assign upd_pc         = head.pc;
    assign upd_target     = head.target;
    assign upd_taken      = head.taken;
    assign upd_br_type    = head.br_type;
    assign upd_csr_branch = head.csr_branch;
    assign upd_bid        = head.bid;
    assign stall          = ((CNT_W + 1)'(DEPTH) - {1'b0, count_q}) < (CNT_W + 1)'(2);
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_br_update_queue.sv
// Self-checking bench for br_update_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_br_update_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BID_W = 3;

    logic             clk = 1'b0;
    logic             rst, flush, upd_ready;
    logic             p0_valid, p0_taken, p0_csr_branch;
    logic [31:0]      p0_pc, p0_target;
    logic [1:0]       p0_br_type;
    logic [BID_W-1:0] p0_bid;
    logic             p1_valid, p1_taken;
    logic [31:0]      p1_pc, p1_target;
    logic [1:0]       p1_br_type;
    logic [BID_W-1:0] p1_bid;
    logic             upd_valid, upd_taken, upd_csr_branch, stall, overflow;
    logic [31:0]      upd_pc, upd_target;
    logic [1:0]       upd_br_type;
    logic [BID_W-1:0] upd_bid;

    always #5 clk = ~clk;

    br_update_queue #(.DEPTH(DEPTH), .BID_W(BID_W)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_pc(p0_pc), .p0_target(p0_target), .p0_taken(p0_taken),
        .p0_br_type(p0_br_type), .p0_csr_branch(p0_csr_branch), .p0_bid(p0_bid),
        .p1_valid(p1_valid), .p1_pc(p1_pc), .p1_target(p1_target), .p1_taken(p1_taken),
        .p1_br_type(p1_br_type), .p1_bid(p1_bid),
        .flush(flush), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_br_type(upd_br_type), .upd_csr_branch(upd_csr_branch), .upd_bid(upd_bid),
        .stall(stall), .overflow(overflow)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      target;
        logic             taken;
        logic [1:0]       br_type;
        logic             csr;
        logic [BID_W-1:0] bid;
    } upd_t;

    upd_t model_q[$];
    logic model_ovf = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; upd_ready = 1'b0;
        p0_valid = 1'b0; p1_valid = 1'b0;
    endtask

    task automatic rand_payload();
        p0_pc = $urandom; p0_target = $urandom; p0_taken = 1'($urandom);
        p0_br_type = 2'($urandom); p0_csr_branch = 1'($urandom); p0_bid = BID_W'($urandom);
        p1_pc = $urandom; p1_target = $urandom; p1_taken = 1'($urandom);
        p1_br_type = 2'($urandom); p1_bid = BID_W'($urandom);
    endtask

    // Called just after inputs are driven (at negedge); checks outputs, then
    // advances the model across the next rising edge.
    task automatic cycle();
        upd_t e0, e1, hd;
        bit   byp, take0, take1, has_head;
        #1;
        e0 = '{p0_pc, p0_target, p0_taken, p0_br_type, p0_csr_branch, p0_bid};
        e1 = '{p1_pc, p1_target, p1_taken, p1_br_type, 1'b0, p1_bid};
        byp = 1'b0;
`ifdef BR_UPDATE_QUEUE_BYPASS_EN
        byp = (model_q.size() == 0) && !flush && (p0_valid || p1_valid);
`endif
        has_head = byp || (model_q.size() > 0);
        if (byp) hd = p0_valid ? e0 : e1;
        else if (has_head) hd = model_q[0];
        check_eq("upd_valid", 64'(upd_valid), 64'(has_head));
        if (has_head) begin
            check_eq("upd_pc", 64'(upd_pc), 64'(hd.pc));
            check_eq("upd_target", 64'(upd_target), 64'(hd.target));
            check_eq("upd_attr", 64'({upd_taken, upd_br_type, upd_csr_branch, upd_bid}),
                     64'({hd.taken, hd.br_type, hd.csr, hd.bid}));
        end
        check_eq("stall", 64'(stall), 64'((DEPTH - model_q.size()) < 2));
        check_eq("overflow", 64'(overflow), 64'(model_ovf));
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            take0 = p0_valid;
            take1 = p1_valid;
            if (byp && upd_ready) begin
                if (p0_valid) take0 = 1'b0;
                else take1 = 1'b0;
            end else if (model_q.size() > 0 && upd_ready) begin
                void'(model_q.pop_front());
            end
            if (take0) begin
                if (model_q.size() < DEPTH) model_q.push_back(e0);
                else model_ovf = 1'b1;
            end
            if (take1) begin
                if (model_q.size() < DEPTH) model_q.push_back(e1);
                else model_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1'b1; cycle();
    endtask

    task automatic dual_push(input logic ready);
        @(negedge clk); idle(); rand_payload();
        p0_valid = 1'b1; p1_valid = 1'b1; upd_ready = ready; cycle();
    endtask

    initial begin
        idle();
        rand_payload();
        rst = 1'b1;
        @(posedge clk);
        do_reset();
        @(negedge clk); idle(); #1;
        check_eq("rst_valid", 64'(upd_valid), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        cycle();

        // Single update flows through to the predictors.
        @(negedge clk); idle(); rand_payload();
        p0_valid = 1'b1; p0_pc = 32'h100; p0_target = 32'h140; p0_taken = 1'b1;
        p0_br_type = 2'b01; upd_ready = 1'b1; cycle();
        @(negedge clk); idle(); upd_ready = 1'b1; cycle();
        @(negedge clk); idle(); upd_ready = 1'b1; cycle();

        // Fill to full, then overflow on a third dual-port cycle.
        dual_push(1'b0);
        dual_push(1'b0);
        dual_push(1'b0);
        @(negedge clk); idle(); #1;
        check_eq("full_stall", 64'(stall), 64'd1);
        check_eq("full_ovf", 64'(overflow), 64'd1);
        cycle();

        // count=3 with a dequeue accepts both ports without overflow.
        do_reset();
        dual_push(1'b0);
        @(negedge clk); idle(); rand_payload(); p0_valid = 1'b1; cycle();
        dual_push(1'b1);
        @(negedge clk); idle(); #1;
        check_eq("deq_room_ovf", 64'(overflow), 64'd0);
        cycle();

        // Flush with an incoming update leaves the queue empty.
        do_reset();
        dual_push(1'b0);
        @(negedge clk); idle(); rand_payload(); p0_valid = 1'b1; flush = 1'b1; cycle();
        @(negedge clk); idle(); #1;
        check_eq("flush_valid", 64'(upd_valid), 64'd0);
        cycle();

        // Seven enqueues interleaved with dequeues wrap the pointers.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); idle(); rand_payload(); p0_valid = 1'b1; p0_pc = 32'(4 * i);
            cycle();
            @(negedge clk); idle(); upd_ready = 1'b1; #1;
            check_eq("wrap_pc", 64'(upd_pc), 64'(4 * i));
            cycle();
        end

`ifdef BR_UPDATE_QUEUE_BYPASS_EN
        // Empty queue, p1 only, ready: consumed in the same cycle.
        @(negedge clk); idle(); rand_payload(); p1_valid = 1'b1; upd_ready = 1'b1; #1;
        check_eq("byp_pc", 64'(upd_pc), 64'(p1_pc));
        cycle();
        @(negedge clk); idle(); #1;
        check_eq("byp_empty", 64'(upd_valid), 64'd0);
        cycle();
`endif

        for (int i = 0; i < 500; i++) begin
            @(negedge clk); idle(); rand_payload();
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            p0_valid  = !rst && ($urandom_range(0, 1) == 1);
            p1_valid  = !rst && ($urandom_range(0, 1) == 1);
            upd_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/br_update_queue.md
BR_UPDATE_QUEUE -- requirements
Module: br_update_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 Parameter BID_W, default 3, branch_id width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 p0_valid  in  1  port 0 (EX0 branch unit) update valid, i.e. valid_jump qualified.
REQ-006 p0_pc, p0_target  in  32 each  orig_pc and jump_address from port 0.
REQ-007 p0_taken  in  1 / p0_br_type  in  2 / p0_csr_branch  in  1 / p0_bid  in  BID_W  port 0 payload.
REQ-008 p1_valid, p1_pc, p1_target, p1_taken, p1_br_type, p1_bid  in  same widths  port 1 (EX1) payload; no csr_branch field.
REQ-009 flush  in  1  discard all queued and incoming updates.
REQ-010 upd_valid  out  1 / upd_ready  in  1  valid/ready handshake toward the predictors (BTB/RAS/direction).
REQ-011 upd_pc, upd_target  out  32 / upd_taken  out  1 / upd_br_type  out  2 / upd_csr_branch  out  1 / upd_bid  out  BID_W  head entry payload.
REQ-012 stall  out  1  issue back-pressure, high when fewer than 2 free entries.
REQ-013 overflow  out  1  sticky flag, set when an update is dropped.

Function
REQ-014 Storage SHALL be a circular FIFO with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and count (0..DEPTH).
REQ-015 Enqueue order within a cycle SHALL be port 0 then port 1; each valid port consumes one entry.
REQ-016 A dequeue SHALL occur when upd_valid and upd_ready are both high at a rising edge.
REQ-017 Free space for the enqueue decision SHALL be DEPTH - count + (dequeue this cycle ? 1 : 0).
REQ-018 If free space is 1 and both ports are valid, port 0 SHALL be stored, port 1 dropped, and overflow set.
REQ-019 If free space is 0, every valid port SHALL be dropped and overflow set.
REQ-020 stall SHALL equal (DEPTH - count) < 2, computed from registered count only.
REQ-021 upd_valid SHALL be high when count > 0, and all upd_* fields SHALL equal the head entry.
REQ-022 upd_* fields SHALL remain stable while upd_valid=1 and upd_ready=0.
REQ-023 Non-bypass latency SHALL be one cycle: an input accepted at edge N is visible at the output in cycle N+1 at the earliest.
REQ-024 flush SHALL set count, wr_ptr and rd_ptr to 0 at the next edge; inputs and any dequeue in that cycle are discarded; overflow is unchanged.
REQ-025 p0_csr_branch SHALL be stored per entry; upd_csr_branch=1 means upd_target is a CSR redirect PC.
REQ-026 count SHALL never exceed DEPTH or underflow; pointer wrap from DEPTH-1 to 0 SHALL need no special case.

Reset
REQ-027 On rst=1 at an edge, count, wr_ptr, rd_ptr and overflow SHALL be 0; upd_valid=0; stall=0; rst overrides flush and all inputs.
REQ-028 Entry payload storage SHALL NOT be reset; upd_* data fields are don't-care while upd_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries in one cycle with no partial dequeue.

Configuration
REQ-030 With macro BR_UPDATE_QUEUE_BYPASS_EN defined, if count=0 and flush=0, the first valid port (p0 if valid, else p1) SHALL drive upd_* combinationally in the same cycle.
REQ-031 In bypass, if upd_ready=1 that update SHALL be consumed without an enqueue; otherwise it SHALL be enqueued normally; the other port, if valid, SHALL always be enqueued.
REQ-032 Without the macro, no combinational input-to-output path SHALL exist, and REQ-023 latency applies.

Verification
REQ-033 Reset, then p0_valid=1 with pc=0x100, target=0x140, taken=1, br_type=01, upd_ready=1 -> next cycle upd_valid=1, upd_pc=0x100, upd_target=0x140; one cycle later count=0.
REQ-034 DEPTH=4, upd_ready=0, two dual-port cycles -> count=4, stall=1 from count=3; a third dual-port cycle -> both dropped, overflow=1.
REQ-035 count=3, upd_ready=1 with dequeue, both ports valid -> both accepted, count=4, no overflow.
REQ-036 count=2, flush=1 with p0_valid=1 -> next cycle count=0, upd_valid=0, p0 update absent.
REQ-037 7 single-port enqueues interleaved with dequeues -> pointers wrap past 3, output order matches input order, pc values 0x0..0x18 step 4.
REQ-038 BR_UPDATE_QUEUE_BYPASS_EN defined, empty queue, p1_valid only, upd_ready=1 -> same-cycle upd_valid=1 with p1 payload, count remains 0.
